uart_console_responder: RTL and testbench



---
 rtl/uart_console_responder_pkg.sv | 29 ++
 rtl/uart_resp_bit_rx.sv | 88 ++++++++
 rtl/uart_console_responder.sv | 166 ++++++++++++++++
 tb/tb_uart_console_responder.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_console_responder_pkg.sv
// Shared constants and state encodings for the console responder: ASCII control
// bytes, frame length and the protocol/receiver state types.
package uart_console_responder_pkg;

  localparam logic [7:0] ASCII_STX = 8'h02;
  localparam logic [7:0] ASCII_ETX = 8'h03;
  localparam logic [7:0] ASCII_EOT = 8'h04;
  localparam logic [7:0] ASCII_ENQ = 8'h05;
  localparam logic [7:0] ASCII_ACK = 8'h06;
  localparam logic [7:0] ASCII_FTX = 8'h07;
  localparam logic [7:0] ASCII_FRX = 8'h08;

  // start + 8 data + stop
  localparam int unsigned FRAME_LEN = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TEXT = 2'd1,
    ST_DONE = 2'd2
  } proto_state_e;

  typedef enum logic [1:0] {
    RX_IDLE      = 2'd0,
    RX_START     = 2'd1,
    RX_BITS      = 2'd2,
    RX_WAIT_HIGH = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_resp_bit_rx.sv
// 8N1 receiver for the console responder: start-bit qualification at half a bit,
// mid-bit sampling of data and stop, one-cycle delivery or framing-error pulse.
module uart_resp_bit_rx
  import uart_console_responder_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] bit_duration,
  input  logic             rxd,
  output logic [7:0]       data,
  output logic             data_valid,
  output logic             frame_err
);

  localparam int unsigned STOP_IDX = FRAME_LEN - 2;

  rx_state_e        state;
  logic [DIV_W-1:0] dur;
  logic [DIV_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [7:0]       shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RX_IDLE;
      dur        <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxd) begin
            dur   <= bit_duration;
            cnt   <= (bit_duration >> 1) - DIV_W'(1);
            state <= RX_START;
          end
        end
        RX_START: begin
          // A start bit that is high again at its midpoint was a glitch
          if (cnt == '0) begin
            if (rxd) begin
              state <= RX_IDLE;
            end else begin
              cnt     <= dur - DIV_W'(1);
              bit_idx <= '0;
              state   <= RX_BITS;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        RX_BITS: begin
          if (cnt == '0) begin
            cnt <= dur - DIV_W'(1);
            if (bit_idx == 4'(STOP_IDX)) begin
              if (rxd) begin
                data       <= shift;
                data_valid <= 1'b1;
                state      <= RX_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= RX_WAIT_HIGH;
              end
            end else begin
              shift   <= {rxd, shift[7:1]};
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt - DIV_W'(1);
          end
        end
        RX_WAIT_HIGH: begin
          if (rxd) state <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_console_responder.sv
// Far-end console peer of uart_core: ACKs ENQ, forwards STX..ETX text, latches EOT.
// Optional build macro UART_RESP_ECHO_EN echoes forwarded text bytes back on TX.
module uart_console_responder
  import uart_console_responder_pkg::*;
#(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned ENQ_CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DIV_W-1:0]     bit_duration_i,
  input  logic                 rxd_i,
  output logic                 txd_o,
  input  logic                 cts_i,
  output logic                 rts_o,
  output logic [7:0]           char_o,
  output logic                 char_valid_o,
  output logic                 eot_o,
  output logic [ENQ_CNT_W-1:0] enq_cnt_o,
  output logic                 frame_err_o
);

  localparam int unsigned LAST_BIT = FRAME_LEN - 1;

  logic [7:0]       rx_data;
  logic             rx_valid;
  proto_state_e     state;
  logic             ack_pend;
  logic             tx_busy;
  logic [8:0]       tx_shift;
  logic [DIV_W-1:0] tx_cnt;
  logic [DIV_W-1:0] tx_dur;
  logic [3:0]       tx_bit;
  logic             tx_start_c;
  logic [7:0]       tx_byte_c;
  logic             enq_c;
  logic             fwd_c;

  uart_resp_bit_rx #(
    .DIV_W(DIV_W)
  ) u_bit_rx (
    .clk          (clk_i),
    .rst          (rst_i),
    .bit_duration (bit_duration_i),
    .rxd          (rxd_i),
    .data         (rx_data),
    .data_valid   (rx_valid),
    .frame_err    (frame_err_o)
  );

  assign enq_c = rx_valid && (state == ST_IDLE) && (rx_data == ASCII_ENQ);
  assign fwd_c = rx_valid && (state == ST_TEXT) &&
                 (rx_data != ASCII_ETX) && (rx_data != ASCII_EOT);

`ifdef UART_RESP_ECHO_EN
  logic       echo_pend;
  logic [7:0] echo_data;

  assign tx_start_c = !tx_busy && cts_i && (state != ST_DONE) && (ack_pend || echo_pend);
  assign tx_byte_c  = ack_pend ? ASCII_ACK : echo_data;

  // Single-entry echo slot; a byte forwarded while it is occupied is not echoed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      echo_pend <= 1'b0;
      echo_data <= '0;
    end else if (tx_start_c && !ack_pend) begin
      echo_pend <= 1'b0;
    end else if (fwd_c && !echo_pend) begin
      echo_pend <= 1'b1;
      echo_data <= rx_data;
    end
  end
`else
  assign tx_start_c = !tx_busy && cts_i && (state != ST_DONE) && ack_pend;
  assign tx_byte_c  = ASCII_ACK;
`endif

  // TX serializer; the cycle spent on the start decision is the inter-frame idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txd_o    <= 1'b1;
      tx_busy  <= 1'b0;
      tx_shift <= '0;
      tx_cnt   <= '0;
      tx_dur   <= '0;
      tx_bit   <= '0;
    end else if (tx_busy) begin
      if (tx_cnt == '0) begin
        if (tx_bit == 4'(LAST_BIT)) begin
          tx_busy <= 1'b0;
        end else begin
          txd_o    <= tx_shift[0];
          tx_shift <= {1'b1, tx_shift[8:1]};
          tx_bit   <= tx_bit + 4'd1;
          tx_cnt   <= tx_dur - DIV_W'(1);
        end
      end else begin
        tx_cnt <= tx_cnt - DIV_W'(1);
      end
    end else if (tx_start_c) begin
      txd_o    <= 1'b0;
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, tx_byte_c};
      tx_dur   <= bit_duration_i;
      tx_cnt   <= bit_duration_i - DIV_W'(1);
      tx_bit   <= '0;
    end
  end

  // Protocol FSM with its registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      rts_o        <= 1'b0;
      char_o       <= '0;
      char_valid_o <= 1'b0;
      eot_o        <= 1'b0;
      enq_cnt_o    <= '0;
      ack_pend     <= 1'b0;
    end else begin
      char_valid_o <= 1'b0;
      rts_o        <= (state != ST_DONE);
      // A start launched this cycle already covers any ENQ arriving now
      if (tx_start_c && ack_pend) begin
        ack_pend <= 1'b0;
      end else if (enq_c) begin
        ack_pend <= 1'b1;
      end
      if (rx_valid) begin
        case (state)
          ST_IDLE: begin
            case (rx_data)
              ASCII_ENQ: begin
                if (enq_cnt_o != '1) enq_cnt_o <= enq_cnt_o + ENQ_CNT_W'(1);
              end
              ASCII_STX: state <= ST_TEXT;
              ASCII_EOT: begin
                state <= ST_DONE;
                eot_o <= 1'b1;
                rts_o <= 1'b0;
              end
              default: ;
            endcase
          end
          ST_TEXT: begin
            case (rx_data)
              ASCII_ETX: state <= ST_IDLE;
              ASCII_EOT: begin
                state <= ST_DONE;
                eot_o <= 1'b1;
                rts_o <= 1'b0;
              end
              default: begin
                char_o       <= rx_data;
                char_valid_o <= 1'b1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_console_responder.sv
// Self-checking bench for uart_console_responder: directed handshake steps plus
// randomized text traffic, checked against a protocol-level model and a TX decoder.
module tb_uart_console_responder;

  localparam logic [7:0] B_STX = 8'h02;
  localparam logic [7:0] B_ETX = 8'h03;
  localparam logic [7:0] B_EOT = 8'h04;
  localparam logic [7:0] B_ENQ = 8'h05;
  localparam logic [7:0] B_ACK = 8'h06;
  localparam int ENQ_MAX = 255;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [15:0] bit_duration_i;
  logic        rxd_i;
  logic        txd_o;
  logic        cts_i;
  logic        rts_o;
  logic [7:0]  char_o;
  logic        char_valid_o;
  logic        eot_o;
  logic [7:0]  enq_cnt_o;
  logic        frame_err_o;

  uart_console_responder dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .bit_duration_i (bit_duration_i),
    .rxd_i          (rxd_i),
    .txd_o          (txd_o),
    .cts_i          (cts_i),
    .rts_o          (rts_o),
    .char_o         (char_o),
    .char_valid_o   (char_valid_o),
    .eot_o          (eot_o),
    .enq_cnt_o      (enq_cnt_o),
    .frame_err_o    (frame_err_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int bd = 100;

  int         m_mode = 0;
  int         m_enq = 0;
  int         m_errs = 0;
  logic [7:0] m_chars[$];
  int         chk_idx = 0;

  logic [7:0] got_chars[$];
  int         got_errs = 0;
  int         both_hi = 0;
  int         cv_long = 0;
  logic       cv_prev = 1'b0;

  logic [7:0] tx_bytes[$];
  bit         tx_ok[$];

  always @(negedge clk) begin
    if (char_valid_o === 1'b1) got_chars.push_back(char_o);
    if (frame_err_o === 1'b1) got_errs <= got_errs + 1;
    if (char_valid_o === 1'b1 && frame_err_o === 1'b1) both_hi <= both_hi + 1;
    if (char_valid_o === 1'b1 && cv_prev === 1'b1) cv_long <= cv_long + 1;
    cv_prev <= char_valid_o;
  end

  // Decode every TX frame and verify each bit holds its level for exactly bd cycles
  always begin : mon_tx
    int d;
    logic s[$];
    logic [9:0] bits;
    bit ok;
    @(negedge clk);
    if (rst_i === 1'b0 && txd_o === 1'b0) begin
      d = int'(bit_duration_i);
      s.delete();
      s.push_back(txd_o);
      for (int i = 1; i <= 10 * d; i++) begin
        @(negedge clk);
        s.push_back(txd_o);
      end
      ok = 1'b1;
      for (int k = 0; k < 10; k++) bits[k] = s[k * d + d / 2];
      for (int i = 0; i < 10 * d; i++) if (s[i] !== bits[i / d]) ok = 1'b0;
      if (s[10 * d] !== 1'b1 || bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      tx_bytes.push_back(bits[8:1]);
      tx_ok.push_back(ok);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_bd(input int v);
    bd = v;
    bit_duration_i = 16'(v);
  endtask

  // Protocol rules applied to one received frame
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      m_errs++;
    end else if (m_mode == 0) begin
      if (b == B_ENQ) m_enq = (m_enq < ENQ_MAX) ? m_enq + 1 : ENQ_MAX;
      else if (b == B_STX) m_mode = 1;
      else if (b == B_EOT) m_mode = 2;
    end else if (m_mode == 1) begin
      if (b == B_ETX) m_mode = 0;
      else if (b == B_EOT) m_mode = 2;
      else m_chars.push_back(b);
    end
  endtask

  task automatic xmit(input logic [7:0] b, input bit good);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rxd_i = f[k];
      repeat (bd) @(negedge clk);
    end
    rxd_i = 1'b1;
    repeat (2) @(negedge clk);
    model_byte(b, good);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_enq_cnt"}, 32'(enq_cnt_o), 32'(m_enq));
    check({tag, "_eot"}, 32'(eot_o), 32'(m_mode == 2));
    check({tag, "_char_count"}, 32'(got_chars.size()), 32'(m_chars.size()));
    check({tag, "_frame_errs"}, 32'(got_errs), 32'(m_errs));
    check({tag, "_err_with_char"}, 32'(both_hi), 32'(0));
    check({tag, "_char_pulse_width"}, 32'(cv_long), 32'(0));
    while (chk_idx < m_chars.size() && chk_idx < got_chars.size()) begin
      check({tag, "_char"}, 32'(got_chars[chk_idx]), 32'(m_chars[chk_idx]));
      chk_idx++;
    end
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget);
    int c = 0;
    while (tx_bytes.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_frame_seen"}, 32'(tx_bytes.size() >= n), 32'(1));
  endtask

  task automatic check_ack(input string tag, input int idx);
    if (tx_bytes.size() > idx) begin
      check({tag, "_byte"}, 32'(tx_bytes[idx]), 32'(B_ACK));
      check({tag, "_timing"}, 32'(tx_ok[idx]), 32'(1));
    end else begin
      check({tag, "_missing"}, 32'(tx_bytes.size()), 32'(idx + 1));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    m_enq = 0;
    m_mode = 0;
  endtask

  initial begin
    int n0;
    int c;
    logic prev;
    logic [7:0] b;
    bit good;

    rst_i = 1'b1;
    rxd_i = 1'b1;
    cts_i = 1'b1;
    set_bd(100);
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd_o), 32'(1));
    check("rst_rts", 32'(rts_o), 32'(0));
    check("rst_char", 32'(char_o), 32'(0));
    check("rst_char_valid", 32'(char_valid_o), 32'(0));
    check("rst_eot", 32'(eot_o), 32'(0));
    check("rst_enq_cnt", 32'(enq_cnt_o), 32'(0));
    check("rst_frame_err", 32'(frame_err_o), 32'(0));
    rst_i = 1'b0;
    @(negedge clk);
    check("rts_after_rst", 32'(rts_o), 32'(1));

    // Single ENQ answered by one ACK
    xmit(B_ENQ, 1'b1);
    check_model("enq1");
    wait_frames("ack1", 1, 3000);
    check_ack("ack1", 0);

    // Three ENQs, the last two merged while cts is low: two ACKs in total
    do_reset();
    check("rst2_enq_cnt", 32'(enq_cnt_o), 32'(0));
    n0 = tx_bytes.size();
    xmit(B_ENQ, 1'b1);
    cts_i = 1'b0;
    xmit(B_ENQ, 1'b1);
    xmit(B_ENQ, 1'b1);
    wait_frames("merge_first", n0 + 1, 3000);
    repeat (500) @(negedge clk);
    check("merge_held_by_cts", 32'(tx_bytes.size()), 32'(n0 + 1));
    cts_i = 1'b1;
    wait_frames("merge_second", n0 + 2, 3000);
    repeat (3000) @(negedge clk);
    check("merge_ack_total", 32'(tx_bytes.size()), 32'(n0 + 2));
    check_ack("merge_ack_a", n0);
    check_ack("merge_ack_b", n0 + 1);
    check_model("merge");

    // Text block: ENQ inside text is forwarded, not acknowledged
    n0 = tx_bytes.size();
    xmit(B_STX, 1'b1);
    xmit(8'h41, 1'b1);
    xmit(B_ENQ, 1'b1);
    xmit(8'h42, 1'b1);
    xmit(B_ETX, 1'b1);
    check_model("text");
    repeat (1500) @(negedge clk);
    check("text_no_ack", 32'(tx_bytes.size()), 32'(n0));

    // Bad stop bit drops the byte; the following ENQ is handled in IDLE
    xmit(8'h55, 1'b0);
    check_model("ferr");
    xmit(B_ENQ, 1'b1);
    check_model("ferr_enq");
    wait_frames("ferr_ack", n0 + 1, 3000);
    check_ack("ferr_ack", n0);

    // Random text at random bit durations, with occasional framing errors
    xmit(B_STX, 1'b1);
    for (int i = 0; i < 24; i++) begin
      set_bd(int'($urandom_range(4, 24)));
      b = 8'($urandom);
      if (b == B_ETX || b == B_EOT) b = b ^ 8'h10;
      good = ($urandom_range(0, 7) != 0);
      xmit(b, good);
      check_model("rand");
    end
    xmit(B_ETX, 1'b1);
    check_model("rand_end");

    // Saturating ENQ counter, then reset in the middle of an ACK frame
    do_reset();
    set_bd(4);
    for (int i = 0; i < 300; i++) xmit(B_ENQ, 1'b1);
    check_model("sat");
    c = 0;
    prev = txd_o;
    while (!(prev === 1'b1 && txd_o === 1'b0) && c < 200) begin
      prev = txd_o;
      @(negedge clk);
      c++;
    end
    check("abort_frame_found", 32'(txd_o), 32'(0));
    rst_i = 1'b1;
    @(negedge clk);
    check("abort_txd_idle", 32'(txd_o), 32'(1));
    check("abort_enq_cnt", 32'(enq_cnt_o), 32'(0));
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    repeat (100) @(negedge clk);
    m_enq = 0;
    m_mode = 0;
    set_bd(100);
    tx_bytes.delete();
    tx_ok.delete();

    // EOT ends the session: counts freeze and the pending ACK never goes out
    cts_i = 1'b0;
    xmit(B_ENQ, 1'b1);
    check_model("pre_eot");
    xmit(B_EOT, 1'b1);
    check_model("eot");
    check("eot_rts", 32'(rts_o), 32'(0));
    xmit(B_ENQ, 1'b1);
    xmit(B_STX, 1'b1);
    xmit(8'h41, 1'b1);
    check_model("done");
    cts_i = 1'b1;
    repeat (3000) @(negedge clk);
    check("done_no_tx", 32'(tx_bytes.size()), 32'(0));
    check("done_rts_held", 32'(rts_o), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
